// File: rtl/reg_pkg.sv
// reg_pkg: shared FSM state type and default widths for the register dump reader
package reg_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} dump_state_t;
  localparam int N           = 8;
  localparam int ADDR_WIDTH  = 5;
  localparam int COUNT_WIDTH = ADDR_WIDTH + 1;
  localparam int REGCOUNT    = 10;
endpackage

// File: rtl/reg_dump_reader_wrap_counter.sv
// wrap_counter: loadable address counter (clk, rst, load/load_val, inc -> q) wrapping regcount-1 to 0
module wrap_counter #(
  parameter int addr_width = 5,
  parameter int regcount   = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  inc,
  input  logic [addr_width-1:0] load_val,
  output logic [addr_width-1:0] q
);
  always_ff @(posedge clk)
    if (rst) q <= '0;
    else if (load) q <= load_val;
    else if (inc) q <= (q == addr_width'(regcount - 1)) ? '0 : q + 1'b1;
endmodule

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: reads Count words from Base (wrapping) via RegAddr/RegData onto an OutData/OutValid/OutReady stream, with Busy/Done/Err status
module reg_dump_reader
  import reg_pkg::*;
#(
  parameter int n          = N,
  parameter int addr_width = ADDR_WIDTH,
  parameter int regcount   = REGCOUNT
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic                  Start,
  input  logic [addr_width-1:0] Base,
  input  logic [addr_width:0]   Count,
  input  logic                  Abort,
  output logic [addr_width-1:0] RegAddr,
  input  logic [n-1:0]          RegData,
  output logic [n-1:0]          OutData,
  output logic                  OutValid,
  input  logic                  OutReady,
  output logic                  Busy,
  output logic                  Done,
  output logic                  Err
);
  localparam int cw = addr_width + 1;
  dump_state_t state, state_n;
  logic [cw-1:0] remaining, remaining_n;
  logic [n-1:0] out_data_n;
  logic out_valid_n, err_n, load, inc, bad;
  assign bad = ({1'b0, Base} >= cw'(regcount)) || (Count > cw'(regcount));
  assign Busy = state != IDLE;
  assign Done = state == DONE;
  wrap_counter #(.addr_width(addr_width), .regcount(regcount)) u_addr (
    .clk(Clock),
    .rst(Reset),
    .load(load),
    .inc(inc),
    .load_val(Base),
    .q(RegAddr)
  );
  always_comb begin
    state_n     = state;
    remaining_n = remaining;
    out_data_n  = OutData;
    out_valid_n = OutValid;
    err_n       = 1'b0;
    load        = 1'b0;
    inc         = 1'b0;
    if (Abort && state != IDLE) begin
      state_n     = IDLE;
      out_valid_n = 1'b0;
    end else begin
      case (state)
        IDLE:
          if (Start) begin
            if (bad) err_n = 1'b1;
            else if (Count == '0) state_n = DONE;
            else begin
              load        = 1'b1;
              remaining_n = Count;
              state_n     = FETCH;
            end
          end
        FETCH: begin
          out_data_n  = RegData;
          out_valid_n = 1'b1;
          state_n     = SEND;
        end
        SEND:
          if (OutReady) begin
            remaining_n = remaining - 1'b1;
            inc         = 1'b1;
            out_valid_n = 1'b0;
            state_n     = (remaining == cw'(1)) ? DONE : FETCH;
          end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge Clock)
    if (Reset) begin
      state     <= IDLE;
      remaining <= '0;
      OutData   <= '0;
      OutValid  <= 1'b0;
      Err       <= 1'b0;
    end else begin
      state     <= state_n;
      remaining <= remaining_n;
      OutData   <= out_data_n;
      OutValid  <= out_valid_n;
      Err       <= err_n;
    end
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: directed and randomized dumps checked against a queue-based reference of the bank
module tb_reg_dump_reader;
  logic Clock = 1'b0;
  logic Reset, Start, Abort, OutReady;
  logic [4:0] Base, RegAddr;
  logic [5:0] Count;
  logic [7:0] RegData, OutData;
  logic OutValid, Busy, Done, Err;
  logic [7:0] bank [32];
  logic [7:0] got_q [$];
  int addr_q [$];
  int hs_q [$];
  int n_asserts = 0;
  int n_fail = 0;
  int dc, ic;
  reg_dump_reader dut (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Base(Base), .Count(Count),
    .Abort(Abort), .RegAddr(RegAddr), .RegData(RegData), .OutData(OutData),
    .OutValid(OutValid), .OutReady(OutReady), .Busy(Busy), .Done(Done), .Err(Err)
  );
  assign RegData = (RegAddr < 5'd10) ? bank[RegAddr] : 8'hxx;
  always #5 Clock = ~Clock;
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_dump(input int base, input int cnt, input int ready_pct, input int stall_word,
                          input int stall_len, input bit noise, input bit abort_start,
                          output int done_c, output int idle_c);
    int stalls, dones, sl;
    bit pending;
    logic [7:0] pdata;
    got_q.delete(); addr_q.delete(); hs_q.delete();
    stalls = 0; dones = 0; sl = stall_len; pending = 0; pdata = '0;
    done_c = -1; idle_c = -1;
    Base = 5'(base); Count = 6'(cnt); Start = 1; Abort = abort_start;
    tick();
    Start = 0; Abort = 0;
    for (int c = 1; c <= 400; c++) begin
      if (pending) begin
        check("hold_valid", OutValid, 1);
        check("hold_data", OutData, pdata);
      end
      if (Done) begin dones++; done_c = c; end
      if (!Busy) begin idle_c = c; break; end
      if (OutValid && int'(got_q.size()) == stall_word && sl > 0) begin
        OutReady = 0; sl--;
      end else OutReady = ($urandom_range(99) < ready_pct);
      Start = noise ? 1'($urandom_range(1)) : 1'b0;
      Base = 5'($urandom_range(9)); Count = 6'($urandom_range(1, 10));
      if (OutValid && OutReady) begin
        got_q.push_back(OutData); addr_q.push_back(int'(RegAddr)); hs_q.push_back(c); pending = 0;
      end else if (OutValid) begin
        stalls++; pending = 1; pdata = OutData;
      end else pending = 0;
      tick();
    end
    Start = 0; OutReady = 0;
    check("timeout", idle_c > 0, 1);
    check("words", got_q.size(), cnt);
    for (int i = 0; i < got_q.size() && i < cnt; i++) begin
      check("data", got_q[i], bank[(base + i) % 10]);
      check("addr", addr_q[i], (base + i) % 10);
    end
    check("done_cnt", dones, 1);
    check("done_cyc", done_c, 2 * cnt + 1 + stalls);
    check("idle_cyc", idle_c, done_c + 1);
    check("regaddr_hold", RegAddr, (base + cnt) % 10);
  endtask
  initial begin
    Reset = 1; Start = 0; Abort = 0; OutReady = 0; Base = 0; Count = 0;
    for (int i = 0; i < 32; i++) bank[i] = 8'(i + 8'h10);
    tick(); tick();
    check("rst_addr", RegAddr, 0);
    check("rst_data", OutData, 0);
    check("rst_valid", OutValid, 0);
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_err", Err, 0);
    Reset = 0;
    tick();
    run_dump(2, 3, 100, -1, 0, 0, 0, dc, ic);
    check("t1_data0", got_q.size() > 0 ? got_q[0] : 8'h00, 8'h12);
    for (int i = 0; i < hs_q.size(); i++) check("t1_hs_cyc", hs_q[i], 2 + 2 * i);
    check("t1_done_cyc", dc, 7);
    check("t1_idle_cyc", ic, 8);
    run_dump(8, 4, 100, -1, 0, 0, 0, dc, ic);
    run_dump(0, 3, 100, 1, 5, 0, 0, dc, ic);
    check("bp_done_cyc", dc, 12);
    Base = 10; Count = 3; Start = 1;
    tick();
    Start = 0;
    check("rej_base_err", Err, 1);
    check("rej_base_busy", Busy, 0);
    tick();
    check("rej_base_err_end", Err, 0);
    check("rej_base_valid", OutValid, 0);
    check("rej_base_busy2", Busy, 0);
    Base = 0; Count = 11; Start = 1;
    tick();
    Start = 0;
    check("rej_cnt_err", Err, 1);
    tick();
    check("rej_cnt_err_end", Err, 0);
    Base = 3; Count = 0; Start = 1;
    tick();
    Start = 0;
    check("cnt0_done", Done, 1);
    check("cnt0_valid", OutValid, 0);
    check("cnt0_err", Err, 0);
    tick();
    check("cnt0_done_end", Done, 0);
    check("cnt0_busy", Busy, 0);
    Base = 1; Count = 3; Start = 1;
    tick();
    Start = 0;
    tick();
    check("ab_valid_pre", OutValid, 1);
    OutReady = 1; Abort = 1;
    tick();
    Abort = 0; OutReady = 0;
    check("ab_valid", OutValid, 0);
    check("ab_busy", Busy, 0);
    check("ab_done", Done, 0);
    check("ab_addr", RegAddr, 1);
    tick();
    check("ab_done2", Done, 0);
    run_dump(0, 1, 100, -1, 0, 0, 0, dc, ic);
    check("ab_after", got_q.size() > 0 ? got_q[0] : 8'h00, 8'h10);
    run_dump(4, 2, 100, -1, 0, 0, 1, dc, ic);
    Base = 0; Count = 3; Start = 1; OutReady = 1;
    tick();
    Start = 0;
    tick(); tick();
    check("rs_pre_busy", Busy, 1);
    check("rs_pre_addr", RegAddr, 1);
    Reset = 1; Start = 1; Abort = 1;
    tick();
    Reset = 0; Start = 0; Abort = 0; OutReady = 0;
    check("rs_addr", RegAddr, 0);
    check("rs_data", OutData, 0);
    check("rs_valid", OutValid, 0);
    check("rs_busy", Busy, 0);
    check("rs_done", Done, 0);
    check("rs_err", Err, 0);
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 10; i++) bank[i] = 8'($urandom);
      run_dump($urandom_range(9), $urandom_range(1, 10), 30 + $urandom_range(70), -1, 0, 1,
               1'($urandom_range(1)), dc, ic);
      Start = 1;
      if ($urandom_range(1) == 1) begin
        Base = 5'($urandom_range(10, 31)); Count = 6'($urandom_range(10));
      end else begin
        Base = 5'($urandom_range(9)); Count = 6'($urandom_range(11, 63));
      end
      tick();
      Start = 0;
      check("rnd_rej_err", Err, 1);
      check("rnd_rej_busy", Busy, 0);
    end
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_dump_reader.md
# reg_dump_reader

Sequential read-out engine for the register bank. On a start command it drives the bank's read address, captures each word, and presents it on a valid/ready output stream. It handles a programmable base and count with wrap-around at `regcount`, and signals completion with a one-cycle `Done` pulse. It sits between the register bank's read port and any debug or trace consumer. While `Busy` is high it owns the bank's address lines, and it never writes the bank.

## Interface
- `n`, 8: data word width
- `addr_width`, 5: register address width
- `regcount`, 10: number of registers in the bank; addresses `0..regcount-1`
- `Clock`  in  1  single clock; all state updates on the rising edge
- `Reset`  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- `Start`  in  1  command strobe; sampled only in IDLE
- `Base`  in  addr_width  first address to read, captured with `Start`
- `Count`  in  addr_width+1  number of words to read, captured with `Start`
- `Abort`  in  1  cancel the current dump
- `RegAddr`  out  addr_width  address driven to the bank's read/select input
- `RegData`  in  n  combinational read data returned by the bank for `RegAddr`
- `OutData`  out  n  stream data
- `OutValid`  out  1  stream valid
- `OutReady`  in  1  stream ready from the consumer
- `Busy`  out  1  high in every state except IDLE
- `Done`  out  1  one-cycle pulse when all words have been transferred
- `Err`  out  1  one-cycle pulse when a command is rejected

## Operation
- States: IDLE, FETCH, SEND, DONE. Each state is defined below.
- IDLE: waits for `Start`.
  - `Start` with `Base>=regcount` or `Count>regcount` → `Err`=1 next cycle, stay IDLE.
  - `Start` with `Count==0` → DONE with no transfers.
  - Otherwise load addr←`Base`, remaining←`Count`, go to FETCH.
- FETCH: `RegAddr`=addr. At the clock edge, `OutData`←`RegData` and `OutValid`←1, then go to SEND.
- SEND: `OutData` and `OutValid` are held stable until `OutValid&&OutReady`. On that handshake:
  - remaining decrements.
  - addr advances: `regcount-1` → 0, otherwise +1.
  - If remaining was 1, go to DONE with `OutValid`←0. Otherwise go to FETCH with `OutValid`←0.
- DONE: `Done`=1 for exactly one cycle, then IDLE.
- `Start` outside IDLE is ignored, with no `Err`.
- `Abort` in FETCH, SEND or DONE → IDLE next cycle with `OutValid`=0. No `Done` is issued and no word is transferred on that cycle, even if `OutReady`=1. `Abort` has priority over the handshake.
- `Abort` in IDLE has no effect, even together with `Start`. `Start` still executes in that case.
- Reset values: state IDLE, addr 0, remaining 0, `RegAddr`=0, `OutData`=0, `OutValid`=0, `Busy`=0, `Done`=0, `Err`=0.
- `RegAddr` always equals the internal addr register. It holds its last value in IDLE after a dump, and is 0 only after reset.
- Width rules:
  - remaining is `addr_width+1` bits and never underflows.
  - addr never leaves the range `0..regcount-1`.
  - `OutData` is copied bit-exact from `RegData`.

## Timing
- `Start` accepted at edge k → FETCH in cycle k+1 → `OutValid`=1 from cycle k+2.
- Throughput: one word per 2 cycles with `OutReady` held high. Each stall cycle adds 1.
- The last handshake at edge j → `Done`=1 in cycle j+1 → IDLE and `Busy`=0 in cycle j+2.
- `Count==0`: `Start` at k → `Done` in cycle k+1.
- `Err` is asserted in cycle k+1 for a rejected `Start` at edge k.
- `Reset` asserted mid-dump → reset values on the next edge, regardless of the other inputs.
- `RegData` must settle within the FETCH cycle; there is no multicycle read path.

## Structure
- Shared package `reg_pkg`:
  - `typedef enum logic [1:0] {IDLE, FETCH, SEND, DONE} dump_state_t`
  - width helper constants derived from `addr_width`
- One sub-module, `wrap_counter #(addr_width, regcount)`. It has synchronous load and an increment enable, wraps at `regcount-1`, and is used for addr.
- remaining is a plain down-counter in the top level.

## Test plan
- Reset, then `Start`, `Base`=2, `Count`=3, `OutReady`=1, bank preloaded with reg[i]=i+0x10:
  - stream is 0x12, 0x13, 0x14 with `OutValid` in cycles 2, 4, 6
  - `Done` in cycle 7, `Busy`=0 in cycle 8
- Wrap: `Base`=8, `Count`=4 → `RegAddr` sequence 8, 9, 0, 1; data 0x18, 0x19, 0x10, 0x11.
- Backpressure: `OutReady` low for 5 cycles on word 2 → `OutData` and `OutValid` stable throughout; no duplicated or lost words; `Done` delayed by 5 cycles.
- Rejects and edge commands:
  - `Base`=10 → `Err` pulse, no `OutValid`, `Busy` stays 0
  - `Count`=11 → `Err` pulse
  - `Count`=0 → `Done` in cycle k+1, no data
- `Abort` in SEND with `OutReady`=1 → no transfer that cycle, IDLE next cycle, no `Done`. A following `Start` `Base`=0, `Count`=1 returns 0x10 normally.
- `Reset` asserted in FETCH of word 2 → all outputs at reset values on the next edge. `Start` during `Busy` is ignored, checked by counting words.
